// File: rtl/fir_frame_arbiter.sv
// +--------------------------------------------------------------------------+
// | fir_frame_arbiter: frame-granular round-robin share of one 4-tap FIR     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_frame_arbiter #(
  parameter int FRAME_LOG     = 7,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_valid,
  input  logic [15:0] ch0_data,
  output logic        ch0_ready,
  input  logic [63:0] ch0_coeff,
  input  logic        ch1_valid,
  input  logic [15:0] ch1_data,
  output logic        ch1_ready,
  input  logic [63:0] ch1_coeff,
  output logic        fir_load,
  output logic [63:0] fir_coeff,
  output logic        fir_valid_in,
  output logic [15:0] fir_data_in,
  input  logic        fir_valid_out,
  input  logic [15:0] fir_data_out,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_chan,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam int CW = FRAME_LOG + 1;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] c_frame_len = CW'(1) << FRAME_LOG;
  localparam logic [CW-1:0] c_last_idx  = c_frame_len - CW'(1);
  localparam logic [TW-1:0] c_timeout   = TW'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_grant;
  logic            r_last_grant;
  logic [CW-1:0]   r_in_cnt;
  logic [CW-1:0]   r_out_cnt;
  logic [TW-1:0]   r_timer;
  logic            r_err;
  logic            r_fir_load;
  logic [63:0]     r_fir_coeff;
  logic            r_fir_valid_in;
  logic [15:0]     r_fir_data_in;
  logic            r_out_valid;
  logic [15:0]     r_out_data;
  logic            r_out_chan;
  logic            r_out_last;

  logic            w_any;
  logic            w_new_grant;
  logic            w_sel_valid;
  logic [15:0]     w_sel_data;
  logic            w_hs;
  logic            w_res_path;
  logic            w_capture;
  logic            w_last_cap;
  logic            w_drop;
  logic            w_timeout;
  logic            w_frame_end;

  // Contention goes to the channel that did not own the previous frame.
  assign w_any       = ch0_valid | ch1_valid;
  assign w_new_grant = (ch1_valid & ~ch0_valid) | (ch0_valid & ch1_valid & ~r_last_grant);

  assign ch0_ready   = (r_state == S_STREAM) & ~r_grant;
  assign ch1_ready   = (r_state == S_STREAM) &  r_grant;
  assign w_sel_valid = r_grant ? ch1_valid : ch0_valid;
  assign w_sel_data  = r_grant ? ch1_data  : ch0_data;
  assign w_hs        = (r_state == S_STREAM) & w_sel_valid;

  // A result is only accepted while a frame owns the FIR and has room left.
  assign w_res_path  = (r_state == S_STREAM) | (r_state == S_DRAIN);
  assign w_capture   = fir_valid_out & w_res_path & (r_out_cnt != c_frame_len);
  assign w_last_cap  = w_capture & (r_out_cnt == c_last_idx);
  assign w_drop      = fir_valid_out & ~w_capture;
  assign w_timeout   = (r_state == S_DRAIN) & ~fir_valid_out & (r_timer == c_timeout);
  assign w_frame_end = (r_state == S_DRAIN) & (w_last_cap | w_timeout);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_LOAD;
      S_LOAD:   w_next = S_STREAM;
      S_STREAM: if (w_hs && (r_in_cnt == c_last_idx)) w_next = S_DRAIN;
      S_DRAIN:  if (w_last_cap || w_timeout) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_in_cnt       <= '0;
      r_out_cnt      <= '0;
      r_timer        <= '0;
      r_err          <= 1'b0;
      r_fir_load     <= 1'b0;
      r_fir_coeff    <= '0;
      r_fir_valid_in <= 1'b0;
      r_fir_data_in  <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_chan     <= 1'b0;
      r_out_last     <= 1'b0;
    end else begin
      r_fir_load     <= 1'b0;
      r_fir_valid_in <= w_hs;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;

      if ((r_state == S_IDLE) && w_any) begin
        r_grant     <= w_new_grant;
        r_fir_load  <= 1'b1;
        r_fir_coeff <= w_new_grant ? ch1_coeff : ch0_coeff;
      end

      if (w_hs) begin
        r_fir_data_in <= w_sel_data;
        r_in_cnt      <= r_in_cnt + CW'(1);
      end

      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_data  <= fir_data_out;
        r_out_chan  <= r_grant;
        r_out_last  <= w_last_cap;
        r_out_cnt   <= r_out_cnt + CW'(1);
      end

      if (r_state == S_DRAIN) begin
        r_timer <= fir_valid_out ? '0 : r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end

      if (w_drop || w_timeout) begin
        r_err <= 1'b1;
      end

      // Frame completion (normal or aborted) wins over the counter updates above.
      if (w_frame_end) begin
        r_last_grant <= r_grant;
        r_in_cnt     <= '0;
        r_out_cnt    <= '0;
        r_timer      <= '0;
      end
    end
  end

  assign fir_load     = r_fir_load;
  assign fir_coeff    = r_fir_coeff;
  assign fir_valid_in = r_fir_valid_in;
  assign fir_data_in  = r_fir_data_in;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_chan     = r_out_chan;
  assign out_last     = r_out_last;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fir_frame_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_fir_frame_arbiter: directed bench with a latency-3 4-tap FIR model    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fir_frame_arbiter;

  localparam int N  = 4;
  localparam int DT = 64;
  localparam logic [63:0] C0 = {16'd6, 16'd5, 16'd6, 16'd2};
  localparam logic [63:0] C1 = {16'd4, 16'd3, 16'd2, 16'd1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ch0_valid, ch1_valid;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_ready, ch1_ready;
  logic [63:0] ch0_coeff = C0;
  logic [63:0] ch1_coeff = C1;
  logic        fir_load, fir_valid_in, fir_valid_out;
  logic [63:0] fir_coeff;
  logic [15:0] fir_data_in, fir_data_out;
  logic        out_valid, out_chan, out_last, busy, err;
  logic [15:0] out_data;

  fir_frame_arbiter #(.FRAME_LOG(2), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready), .ch0_coeff(ch0_coeff),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready), .ch1_coeff(ch1_coeff),
    .fir_load(fir_load), .fir_coeff(fir_coeff),
    .fir_valid_in(fir_valid_in), .fir_data_in(fir_data_in),
    .fir_valid_out(fir_valid_out), .fir_data_out(fir_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // FIR model: y = t1*x[n] + t2*x[n-1] + t3*x[n-2] + t4*x[n-3], latency 3
  logic [2:0]        pv;
  logic [2:0][15:0]  pd;
  logic [2:0][15:0]  hist;
  logic [15:0]       y;
  int                mcnt;
  int                m_limit = N;
  logic              m_stray = 1'b0;

  assign y = 16'(32'(fir_coeff[15:0])  * 32'(fir_data_in) +
                 32'(fir_coeff[31:16]) * 32'(hist[0]) +
                 32'(fir_coeff[47:32]) * 32'(hist[1]) +
                 32'(fir_coeff[63:48]) * 32'(hist[2]));
  assign fir_valid_out = (pv[2] && (mcnt < m_limit)) || m_stray;
  assign fir_data_out  = pd[2];

  always @(posedge clk) begin
    if (!rst) begin
      pv   <= '0;
      pd   <= '0;
      hist <= '0;
      mcnt <= 0;
    end else begin
      pv <= {pv[1:0], fir_valid_in};
      pd <= {pd[1:0], y};
      if (fir_load) begin
        hist <= '0;
        mcnt <= 0;
      end else begin
        if (fir_valid_in) hist <= {hist[1:0], fir_data_in};
        if (pv[2] && (mcnt < m_limit)) mcnt <= mcnt + 1;
      end
    end
  end

  typedef struct {
    logic             chan;
    logic [3:0][15:0] din;
    logic [3:0][15:0] dout;
  } vec_t;

  vec_t tv[6];

  function automatic vec_t mk(input logic c, input logic [15:0] a0, a1, a2, a3,
                              input logic [15:0] e0, e1, e2, e3);
    vec_t v;
    v.chan = c;
    v.din  = {a3, a2, a1, a0};
    v.dout = {e3, e2, e1, e0};
    return v;
  endfunction

  // Sources: each channel streams its queue; bubN makes valid toggle each cycle
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        bub0 = 1'b0, bub1 = 1'b0;
  logic        h0, h1, ph0 = 1'b0, ph1 = 1'b0;

  initial begin
    ch0_valid = 1'b0;
    ch0_data  = '0;
    forever begin
      @(negedge clk);
      h0 = ch0_valid && ch0_ready;
      @(posedge clk);
      #1;
      if (h0 && (q0.size() > 0)) void'(q0.pop_front());
      ph0       = ~ph0;
      ch0_valid = (q0.size() > 0) && (!bub0 || ph0);
      ch0_data  = (q0.size() > 0) ? q0[0] : 16'd0;
    end
  end

  initial begin
    ch1_valid = 1'b0;
    ch1_data  = '0;
    forever begin
      @(negedge clk);
      h1 = ch1_valid && ch1_ready;
      @(posedge clk);
      #1;
      if (h1 && (q1.size() > 0)) void'(q1.pop_front());
      ph1       = ~ph1;
      ch1_valid = (q1.size() > 0) && (!bub1 || ph1);
      ch1_data  = (q1.size() > 0) ? q1[0] : 16'd0;
    end
  end

  // Monitor
  logic [15:0] cap_d[$];
  logic        cap_c[$];
  logic        cap_l[$];
  logic [63:0] loads[$];
  int          cyc = 0, load_cyc = 0, rdy_gap = -1;
  int          nvin = 0, hs1 = 0, r1cyc = 0, viol = 0;
  logic        seen_rdy = 1'b1;
  logic        owner = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (fir_load) begin
        loads.push_back(fir_coeff);
        load_cyc = cyc;
        seen_rdy = 1'b0;
        owner    = (fir_coeff == C1);
      end
      if ((ch0_ready || ch1_ready) && !seen_rdy) begin
        seen_rdy = 1'b1;
        rdy_gap  = cyc - load_cyc;
      end
      if (fir_valid_in) nvin++;
      if (out_valid) begin
        cap_d.push_back(out_data);
        cap_c.push_back(out_chan);
        cap_l.push_back(out_last);
      end
      if (ch1_valid && ch1_ready) hs1++;
      if (ch1_ready) r1cyc++;
      if ((!owner && ch1_ready) || (owner && ch0_ready)) viol++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k);
    for (int i = 0; i < N; i++) begin
      if (tv[k].chan) q1.push_back(tv[k].din[i]);
      else            q0.push_back(tv[k].din[i]);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_coeff"}, fir_coeff, 64'd0);
    chk({tag, "_flags"}, 64'({fir_load, fir_valid_in, out_valid, out_chan, out_last,
                              busy, err, ch0_ready, ch1_ready}), 64'd0);
    chk({tag, "_data"}, 64'({fir_data_in, out_data}), 64'd0);
  endtask

  task automatic wait_frame_done(input string tag);
    int t;
    t = 0;
    while (!busy && (t < 50)) begin tick(); t++; end
    chk({tag, "_started"}, 64'(busy), 64'd1);
    t = 0;
    while (busy && (t < 300)) begin tick(); t++; end
    chk({tag, "_ended"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic check_frame(input int k, input int base, input string tag);
    for (int i = 0; i < N; i++) begin
      if (base + i < cap_d.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 64'(cap_d[base+i]), 64'(tv[k].dout[i]));
        chk($sformatf("%s_chan%0d", tag, i), 64'(cap_c[base+i]), 64'(tv[k].chan));
        chk($sformatf("%s_last%0d", tag, i), 64'(cap_l[base+i]), 64'(i == N - 1));
      end else begin
        chk($sformatf("%s_missing%0d", tag, i), 64'(cap_d.size()), 64'(base + i + 1));
      end
    end
  endtask

  function automatic logic [63:0] load_at(input int idx);
    return (idx < loads.size()) ? loads[idx] : 64'hDEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, cb, vb, hb, rb, t, t3, nres, nl;
    logic eprev;

    tv[0] = mk(1'b0, 16'd1,  16'd2,  16'd3,  16'd4,  16'd2,  16'd10, 16'd23,  16'd42);
    tv[1] = mk(1'b0, 16'd5,  16'd6,  16'd7,  16'd8,  16'd10, 16'd42, 16'd75,  16'd118);
    tv[2] = mk(1'b1, 16'd10, 16'd20, 16'd30, 16'd40, 16'd10, 16'd40, 16'd100, 16'd200);
    tv[3] = mk(1'b0, 16'd1,  16'd1,  16'd1,  16'd1,  16'd2,  16'd8,  16'd13,  16'd19);
    tv[4] = mk(1'b1, 16'd0,  16'd0,  16'd0,  16'd1,  16'd0,  16'd0,  16'd0,   16'd1);
    tv[5] = mk(1'b1, 16'd3,  16'd0,  16'd2,  16'd1,  16'd3,  16'd6,  16'd11,  16'd17);

    rst = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // Single channel frame
    lb = loads.size(); cb = cap_d.size(); vb = nvin;
    push(0);
    wait_frame_done("single");
    chk("single_load", load_at(lb), C0);
    chk("single_rdy_gap", 64'(rdy_gap), 64'd1);
    chk("single_vin", 64'(nvin - vb), 64'd4);
    chk("single_ncap", 64'(cap_d.size() - cb), 64'd4);
    check_frame(0, cb, "single");
    chk("single_busy", 64'(busy), 64'd0);

    // Contention from reset: ch0, ch1, ch0, ch1
    rst = 1'b0; tick(); rst = 1'b1; tick();
    lb = loads.size(); cb = cap_d.size(); vb = viol;
    push(1); push(3); push(2); push(4);
    for (int f = 0; f < 4; f++) wait_frame_done($sformatf("cont%0d", f));
    for (int f = 0; f < 4; f++)
      chk($sformatf("cont_load%0d", f), load_at(lb + f), (f % 2 == 0) ? C0 : C1);
    check_frame(1, cb,      "cont_f0");
    check_frame(2, cb + 4,  "cont_f1");
    check_frame(3, cb + 8,  "cont_f2");
    check_frame(4, cb + 12, "cont_f3");
    chk("cont_ready_excl", 64'(viol - vb), 64'd0);

    // Bubbles on ch1
    cb = cap_d.size(); vb = nvin; hb = hs1; rb = r1cyc;
    bub1 = 1'b1;
    push(5);
    wait_frame_done("bub");
    bub1 = 1'b0;
    chk("bub_hs", 64'(hs1 - hb), 64'd4);
    chk("bub_vin", 64'(nvin - vb), 64'd4);
    chk("bub_rdy_span", 64'(((r1cyc - rb) >= 7) && ((r1cyc - rb) <= 8)), 64'd1);
    check_frame(5, cb, "bub");

    // Drain timeout: FIR returns only 3 results
    m_limit = 3;
    cb = cap_d.size();
    push(0);
    t = 0;
    while (!busy && (t < 50)) begin tick(); t++; end
    nres = 0; t3 = -1000; t = 0; eprev = 1'b1;
    while (busy && (t < 400)) begin
      eprev = err;
      tick();
      t++;
      if (out_valid) begin
        nres++;
        if (nres == 3) t3 = t;
      end
    end
    chk("to_len", 64'(t - t3), 64'(DT + 1));
    chk("to_err_before", 64'(eprev), 64'd0);
    chk("to_err", 64'(err), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_nres", 64'(nres), 64'd3);
    tick();
    nl = 0;
    for (int i = cb; i < cap_d.size(); i++) if (cap_l[i]) nl++;
    chk("to_nolast", 64'(nl), 64'd0);
    for (int i = 0; i < 3; i++)
      if (cb + i < cap_d.size())
        chk($sformatf("to_data%0d", i), 64'(cap_d[cb+i]), 64'(tv[0].dout[i]));
    m_limit = N;
    cb = cap_d.size();
    push(2);
    wait_frame_done("after_to");
    check_frame(2, cb, "after_to");

    // Reset in the middle of a ch1 frame
    hb = hs1;
    push(2);
    t = 0;
    while (((hs1 - hb) < 2) && (t < 50)) begin tick(); t++; end
    chk("midrst_reached", 64'(hs1 - hb >= 2), 64'd1);
    rst = 1'b0;
    q1.delete();
    tick();
    check_idle("midrst");
    rst = 1'b1;
    cb = cap_d.size();
    repeat (6) tick();
    chk("midrst_noout", 64'(cap_d.size() - cb), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    lb = loads.size(); cb = cap_d.size();
    push(1); push(2);
    wait_frame_done("prio0");
    wait_frame_done("prio1");
    chk("prio_load0", load_at(lb), C0);
    chk("prio_load1", load_at(lb + 1), C1);
    check_frame(1, cb,     "prio_f0");
    check_frame(2, cb + 4, "prio_f1");

    // Stray FIR result in IDLE
    chk("stray_err0", 64'(err), 64'd0);
    cb = cap_d.size();
    m_stray = 1'b1;
    tick();
    m_stray = 1'b0;
    repeat (3) tick();
    chk("stray_noout", 64'(cap_d.size() - cb), 64'd0);
    chk("stray_err", 64'(err), 64'd1);
    chk("stray_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
